// File: rtl/mux_nway_reg.sv
// Registered NUM_IN:1 channel select with valid/ready handshake and out-of-range flag/count.
// Optional round-robin scan mode is enabled by defining MUX_SCAN_EN.
module mux_nway_reg #(
   parameter int NUM_IN = 31,
   parameter int WIDTH  = 2,
   parameter int SEL_W  = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
`ifdef MUX_SCAN_EN
   input  logic                    scan_en,
`endif
   output logic [7:0]              err_cnt
);

   localparam int               NUM_SLOTS = 1 << SEL_W;
   localparam logic [SEL_W:0]   NUM_IN_W  = NUM_IN[SEL_W:0];
   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_IN - 1);
   localparam logic [7:0]       CNT_MAX   = 8'hFF;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic             out_err_q, out_err_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] chan [NUM_SLOTS];
   logic [SEL_W-1:0] eff_sel;
   logic             sel_ok;
   logic             accept;

   // Unused select codes map to zero so the mux never indexes past in_data.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_chan
      if (g < NUM_IN) begin : g_used
         assign chan[g] = in_data[g*WIDTH +: WIDTH];
      end else begin : g_unused
         assign chan[g] = '0;
      end
   end

`ifdef MUX_SCAN_EN
   logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

   assign eff_sel = scan_en ? scan_ptr_q : sel;

   always_comb begin
      scan_ptr_d = scan_ptr_q;
      if (accept && scan_en) begin
         scan_ptr_d = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) scan_ptr_q <= '0;
      else       scan_ptr_q <= scan_ptr_d;
   end
`else
   assign eff_sel = sel;
`endif

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign sel_ok   = {1'b0, eff_sel} < NUM_IN_W;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      err_cnt_d   = err_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_sel_d   = eff_sel;
         out_data_d  = sel_ok ? chan[eff_sel] : '0;
         out_err_d   = !sel_ok;
         if (!sel_ok && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Scoreboard bench for mux_nway_reg; scan-mode scenario is built when MUX_SCAN_EN is defined.
module tb_mux_nway_reg;
   localparam int NUM_IN = 31;
   localparam int WIDTH  = 2;
   localparam int SEL_W  = 5;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             err;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_IN*WIDTH-1:0] in_data = '0;
   logic [SEL_W-1:0]        sel = '0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [7:0]              err_cnt;
   logic                    scan_en_v = 1'b0;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t sb_q[$];
   logic m_valid = 1'b0;
   int   m_cnt   = 0;
   int   m_scan  = 0;

   always #5 clk = ~clk;

   mux_nway_reg #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MUX_SCAN_EN
      .scan_en   (scan_en_v),
`endif
      .err_cnt   (err_cnt)
   );

   // Channel k carries (k + off) mod 4.
   function automatic logic [NUM_IN*WIDTH-1:0] make_bus(input int off);
      logic [NUM_IN*WIDTH-1:0] b;
      for (int k = 0; k < NUM_IN; k++) b[k*WIDTH +: WIDTH] = WIDTH'((k + off) % 4);
      return b;
   endfunction

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         total_cnt++;
         $display("FAIL sb_empty: result produced with no expected entry");
         return;
      end
      e = sb_q.pop_front();
      total_cnt++;
      if (out_data !== e.data) $display("FAIL sb_data: got %0d want %0d", out_data, e.data);
      else pass_cnt++;
      total_cnt++;
      if (out_sel !== e.sel) $display("FAIL sb_sel: got %0d want %0d", out_sel, e.sel);
      else pass_cnt++;
      total_cnt++;
      if (out_err !== e.err) $display("FAIL sb_err: got %0b want %0b", out_err, e.err);
      else pass_cnt++;
   endtask

   // Drives one cycle from posedge+1, predicts the result, then checks at the next posedge+1.
   task automatic step(input logic v, input logic [SEL_W-1:0] s, input int off, input logic rdy);
      logic                    exp_rdy, acc;
      logic [SEL_W-1:0]        eff;
      logic [NUM_IN*WIDTH-1:0] bus;
      exp_t                    e;
      bus = make_bus(off);
      in_valid = v; sel = s; in_data = bus; out_ready = rdy;
      #1;
      exp_rdy = !m_valid || rdy;
      total_cnt++;
      if (in_ready !== exp_rdy) $display("FAIL in_ready: got %0b want %0b", in_ready, exp_rdy);
      else pass_cnt++;
      acc = v && exp_rdy;
      eff = scan_en_v ? SEL_W'(m_scan) : s;
      if (acc) begin
         e.sel = eff;
         if (int'(eff) < NUM_IN) begin
            e.data = bus[int'(eff)*WIDTH +: WIDTH];
            e.err  = 1'b0;
         end else begin
            e.data = '0;
            e.err  = 1'b1;
            if (m_cnt != 255) m_cnt++;
         end
         sb_q.push_back(e);
         if (scan_en_v) m_scan = (m_scan == NUM_IN - 1) ? 0 : m_scan + 1;
         m_valid = 1'b1;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc) sb_check();
      total_cnt++;
      if (out_valid !== m_valid) $display("FAIL out_valid: got %0b want %0b", out_valid, m_valid);
      else pass_cnt++;
      total_cnt++;
      if (err_cnt !== 8'(m_cnt)) $display("FAIL err_cnt: got %0d want %0d", err_cnt, m_cnt);
      else pass_cnt++;
   endtask

   task automatic apply_reset();
      in_valid = 1'b0; out_ready = 1'b0; scan_en_v = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b0;
      m_valid = 1'b0; m_cnt = 0; m_scan = 0;
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if ({out_data, out_sel, out_err, out_valid, err_cnt} !== '0)
         $display("FAIL reset_outputs: got data=%0d sel=%0d err=%0b valid=%0b cnt=%0d want all 0",
                  out_data, out_sel, out_err, out_valid, err_cnt);
      else pass_cnt++;
      apply_reset();
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_sweep();
      for (int k = 0; k < NUM_IN; k++) begin
         step(1'b1, SEL_W'(k), 0, 1'b1);
         if (k == 12) begin
            total_cnt++;
            if (out_data !== 2'd0) $display("FAIL sweep_sel12: got %0d want 0", out_data);
            else pass_cnt++;
         end
         if (k == 30) begin
            total_cnt++;
            if (out_data !== 2'd2) $display("FAIL sweep_sel30: got %0d want 2", out_data);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_out_of_range();
      step(1'b1, 5'd31, 0, 1'b1);
      total_cnt++;
      if (out_err !== 1'b1 || out_data !== 2'd0 || out_sel !== 5'd31 || err_cnt !== 8'd1)
         $display("FAIL oor_first: got err=%0b data=%0d sel=%0d cnt=%0d want 1/0/31/1",
                  out_err, out_data, out_sel, err_cnt);
      else pass_cnt++;
      for (int i = 0; i < 300; i++) step(1'b1, 5'd31, i, 1'b1);
      total_cnt++;
      if (err_cnt !== 8'd255) $display("FAIL oor_saturate: got %0d want 255", err_cnt);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      step(1'b1, 5'd5, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 5'd7, i + 1, 1'b0);
         total_cnt++;
         if (out_data !== 2'd1 || out_sel !== 5'd5)
            $display("FAIL stall_hold: got data=%0d sel=%0d want 1/5", out_data, out_sel);
         else pass_cnt++;
      end
      step(1'b1, 5'd7, 0, 1'b1);
      total_cnt++;
      if (out_data !== 2'd3) $display("FAIL stall_release: got %0d want 3", out_data);
      else pass_cnt++;
   endtask

   task automatic test_drain();
      step(1'b0, 5'd0, 2, 1'b1);
      total_cnt++;
      if (out_valid !== 1'b0 || out_data !== 2'd3)
         $display("FAIL drain: got valid=%0b data=%0d want 0/3", out_valid, out_data);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 5'd31, 0, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || err_cnt !== 8'd0)
         $display("FAIL async_reset: got valid=%0b cnt=%0d want 0/0", out_valid, err_cnt);
      else pass_cnt++;
      m_valid = 1'b0; m_cnt = 0; m_scan = 0;
      sb_q.delete();
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

`ifdef MUX_SCAN_EN
   task automatic test_scan();
      apply_reset();
      scan_en_v = 1'b1;
      for (int k = 0; k < 33; k++) begin
         step(1'b1, 5'd31, k, 1'b1);
         total_cnt++;
         if (out_sel !== SEL_W'(k % NUM_IN)) $display("FAIL scan_seq: got %0d want %0d", out_sel, k % NUM_IN);
         else pass_cnt++;
      end
      scan_en_v = 1'b0;
      step(1'b1, 5'd31, 0, 1'b1);
      total_cnt++;
      if (out_err !== 1'b1) $display("FAIL scan_off_err: got %0b want 1", out_err);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_sweep();
      test_out_of_range();
      test_backpressure();
      test_drain();
      test_async_reset();
`ifdef MUX_SCAN_EN
      test_scan();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
